// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared types and constants for the UART RX parity path.
//   - par_mode_e     : parity mode encoding as driven on PAR_MODE
//   - par_state_e    : parity engine FSM states
//   - bit_cnt_w()    : bit counter width for a given data width
//   - BIT_CNT_W      : bit counter width for the default 8-bit data width
package uart_rx_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10
    } par_state_e;

    // Counter must hold values 0..data_width inclusive.
    function automatic int unsigned bit_cnt_w(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned BIT_CNT_W      = $clog2(DATA_WIDTH_DEF + 1);

endpackage

// File: rtl/uart_parity_engine_counter.sv
// parity_err_counter
//   Saturating parity error counter. An increment coinciding with a clear
//   restarts the count at 1 so the new error is not lost.
//   Ports:
//     parity_check_clk  in   clock
//     parity_check_rst  in   asynchronous active-low reset
//     inc               in   count one error this cycle
//     clr               in   clear the count
//     count             out  WIDTH-bit saturating count
module parity_err_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             parity_check_clk,
    input  logic             parity_check_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            if (clr) begin
                count_d = WIDTH'(1);
            end else if (!(&count_q)) begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge parity_check_clk or negedge parity_check_rst) begin
        if (!parity_check_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_parity_engine.sv
// uart_parity_engine
//   Serial parity engine for the UART RX path. Assembles LSB-first data bits
//   into P_DATA, computes parity on the fly (even/odd/mark/space), checks the
//   received parity bit and tracks a sticky error flag and error counter.
//   Optional feature macro: UART_PARITY_ERR_CNT_EN (error counter present;
//   when undefined err_count is tied to 0).
//   Ports:
//     parity_check_clk  in   clock
//     parity_check_rst  in   asynchronous active-low reset
//     frame_start       in   start-bit pulse; latches config, clears frame
//     bit_valid         in   sampled_bit strobe
//     sampled_bit       in   serial bit, LSB first
//     data_len          in   data bits per frame (0 or >DATA_WIDTH = DATA_WIDTH)
//     par_en            in   frame carries a parity bit
//     PAR_MODE          in   00 even, 01 odd, 10 mark, 11 space
//     err_clr           in   clear sticky flag and counter
//     P_DATA            out  assembled data
//     chk_done          out  one-cycle frame-complete pulse
//     par_err           out  parity error of last completed frame
//     par_err_sticky    out  sticky parity error flag
//     err_count         out  saturating parity error count
module uart_parity_engine
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     parity_check_clk,
    input  logic                     parity_check_rst,
    input  logic                     frame_start,
    input  logic                     bit_valid,
    input  logic                     sampled_bit,
    input  logic [3:0]               data_len,
    input  logic                     par_en,
    input  logic [1:0]               PAR_MODE,
    input  logic                     err_clr,
    output logic [DATA_WIDTH-1:0]    P_DATA,
    output logic                     chk_done,
    output logic                     par_err,
    output logic                     par_err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int unsigned CNT_W = bit_cnt_w(DATA_WIDTH);
    localparam logic [4:0]  DW_5  = 5'(DATA_WIDTH);

    par_state_e            state_q,    state_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0]      len_q,      len_d;
    logic                  par_en_q,   par_en_d;
    par_mode_e             mode_q,     mode_d;
    logic                  xor_q,      xor_d;
    logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
    logic                  chk_done_q, chk_done_d;
    logic                  par_err_q,  par_err_d;
    logic                  sticky_q,   sticky_d;

    logic [CNT_W-1:0]      len_clamped;
    logic                  exp_par;
    logic                  err_hit;

    always_comb begin
        len_clamped = CNT_W'(data_len);
        if ((data_len == 4'd0) || ({1'b0, data_len} > DW_5)) begin
            len_clamped = CNT_W'(DATA_WIDTH);
        end
    end

    always_comb begin
        exp_par = 1'b0;
        unique case (mode_q)
            PAR_EVEN:  exp_par = xor_q;
            PAR_ODD:   exp_par = ~xor_q;
            PAR_MARK:  exp_par = 1'b1;
            PAR_SPACE: exp_par = 1'b0;
            default:   exp_par = 1'b0;
        endcase
    end

    // frame_start overrides everything, including a same-cycle bit_valid,
    // so an in-flight frame aborts without a chk_done pulse.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        mode_d     = mode_q;
        xor_d      = xor_q;
        p_data_d   = p_data_q;
        par_err_d  = par_err_q;
        chk_done_d = 1'b0;

        if (frame_start) begin
            state_d   = DATA;
            len_d     = len_clamped;
            par_en_d  = par_en;
            mode_d    = par_mode_e'(PAR_MODE);
            bit_cnt_d = '0;
            xor_d     = 1'b0;
            p_data_d  = '0;
            par_err_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                DATA: begin
                    if (bit_valid) begin
                        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt_q == CNT_W'(i)) begin
                                p_data_d[i] = sampled_bit;
                            end
                        end
                        xor_d     = xor_q ^ sampled_bit;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == (len_q - CNT_W'(1))) begin
                            if (par_en_q) begin
                                state_d = PARITY;
                            end else begin
                                state_d    = IDLE;
                                chk_done_d = 1'b1;
                                par_err_d  = 1'b0;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        par_err_d  = (sampled_bit != exp_par);
                        chk_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign err_hit = chk_done_q & par_err_q;

    // A new error beats a coinciding clear.
    always_comb begin
        sticky_d = sticky_q;
        if (err_hit) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge parity_check_clk or negedge parity_check_rst) begin
        if (!parity_check_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            mode_q     <= PAR_EVEN;
            xor_q      <= 1'b0;
            p_data_q   <= '0;
            chk_done_q <= 1'b0;
            par_err_q  <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            mode_q     <= mode_d;
            xor_q      <= xor_d;
            p_data_q   <= p_data_d;
            chk_done_q <= chk_done_d;
            par_err_q  <= par_err_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef UART_PARITY_ERR_CNT_EN
    parity_err_counter #(
        .WIDTH(ERR_CNT_WIDTH)
    ) u_err_counter (
        .parity_check_clk(parity_check_clk),
        .parity_check_rst(parity_check_rst),
        .inc             (err_hit),
        .clr             (err_clr),
        .count           (err_count)
    );
`else
    assign err_count = '0;
`endif

    assign P_DATA         = p_data_q;
    assign chk_done       = chk_done_q;
    assign par_err        = par_err_q;
    assign par_err_sticky = sticky_q;

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

- Serial parity engine for the UART RX path.
- Collects data bits one at a time from the sampler strobe and assembles `P_DATA`.
- Computes parity on the fly in one of four modes, checks the received parity bit, and keeps a sticky error flag and a saturating error counter.
- Sits between the RX data sampler and the RX FSM, and takes over the single-mode, fixed-width checking that was done before.

## Interface
- `DATA_WIDTH`, default 8: maximum data bits per frame (supported range 5..9).
- `ERR_CNT_WIDTH`, default 8: width of the parity error counter.
- `parity_check_clk`  in  1  clock; reset `parity_check_rst`, asynchronous, active-low.
- `parity_check_rst`  in  1  asynchronous active-low reset.
- `frame_start`  in  1  one-cycle pulse at the start bit; latches the configuration and clears the accumulator.
- `bit_valid`  in  1  one-cycle strobe: `sampled_bit` is valid.
- `sampled_bit`  in  1  sampled serial bit, LSB first.
- `data_len`  in  4  number of data bits in the frame; 0 or >`DATA_WIDTH` means `DATA_WIDTH`.
- `par_en`  in  1  1 = the frame carries a parity bit.
- `PAR_MODE`  in  2  00 even, 01 odd, 10 mark (expected 1), 11 space (expected 0).
- `err_clr`  in  1  clears the sticky flag and the counter.
- `P_DATA`  out  `DATA_WIDTH`  assembled data; unused upper bits are 0.
- `chk_done`  out  1  one-cycle pulse: frame check complete.
- `par_err`  out  1  parity error of the last completed frame.
- `par_err_sticky`  out  1  set by any parity error, cleared by `err_clr`.
- `err_count`  out  `ERR_CNT_WIDTH`  saturating count of parity errors.

## Operation
- FSM states: `IDLE`, `DATA`, `PARITY`.
- `IDLE`:
  - `bit_valid` is ignored.
  - `frame_start` goes to `DATA`.
- Every `frame_start` (in any state):
  - latches `data_len` (after clamping), `par_en` and `PAR_MODE`;
  - clears `P_DATA`, the bit counter, the running XOR and `par_err`.
- `DATA`: on `bit_valid`:
  - `P_DATA[bit_cnt] <= sampled_bit`; running XOR `^= sampled_bit`; `bit_cnt++`.
  - On the last data bit (`bit_cnt == len-1`): with `par_en`, go to `PARITY`; without it, go to `IDLE`, pulse `chk_done` and set `par_err = 0`.
- `PARITY`: on `bit_valid`:
  - expected bit is XOR for even, ~XOR for odd, 1 for mark, 0 for space;
  - `par_err <= (sampled_bit != expected)`; pulse `chk_done`; go to `IDLE`.
- `frame_start` has priority over `bit_valid` in the same cycle. That cycle's bit is dropped and the frame restarts (mid-frame abort, no `chk_done`).
- Configuration inputs are don't-care except in the `frame_start` cycle.
- Sticky flag and counter update when `chk_done && par_err`.
  - Counter saturates at all-ones.
  - If `err_clr` coincides with a new error, the new error wins: sticky = 1, count = 1.
  - `err_clr` alone: sticky = 0, count = 0.
- `P_DATA` and `par_err` hold from `chk_done` until the next `frame_start`.

## Timing
- Reset values: state `IDLE`, `P_DATA` 0, `chk_done` 0, `par_err` 0, `par_err_sticky` 0, `err_count` 0.
- All outputs are registered; no combinational path from inputs to outputs.
- `chk_done` and `par_err` update on the edge that samples the final `bit_valid` (latency 1 clock).
- `par_err_sticky` and `err_count` update on the edge after `chk_done`.
- Back-to-back `bit_valid` on consecutive cycles is supported. Minimum `frame_start` spacing is 1 cycle.
- Reset asserted mid-frame returns everything to reset values immediately.

## Configuration
- `UART_PARITY_ERR_CNT_EN` defined: error counter present as described above.
- Not defined:
  - counter logic is removed and `err_count` is tied to 0;
  - `par_err_sticky` and `err_clr` still function.

## Structure
- `uart_rx_pkg` holds:
  - the `par_mode_e` enum (EVEN/ODD/MARK/SPACE);
  - the FSM state enum;
  - the `BIT_CNT_W = $clog2(DATA_WIDTH+1)` helper constant.
- One sub-module: `parity_err_counter` (saturating counter, clear-vs-increment priority). It is instantiated only under `UART_PARITY_ERR_CNT_EN`.

## Test plan
- Even parity: len 8, data 0xA5 LSB first, parity bit 0.
  - Expected: `chk_done` 1 cycle later, `P_DATA` = 0xA5, `par_err` = 0, `err_count` = 0.
- Odd parity, same data, parity bit 0.
  - Expected: `par_err` = 1, sticky = 1, `err_count` = 1.
- Mark then space: len 7, data 0x3C.
  - Mark with parity bit 0: error.
  - Space with parity bit 0: no error.
  - Expected: `P_DATA` = 0x3C, upper bit 0, `err_count` = 1.
- `par_en` = 0, len 5, data 0x1F.
  - Expected: `chk_done` on the 5th bit, `par_err` = 0, `P_DATA` = 0x1F.
- Abort: `frame_start` together with the 4th `bit_valid` of a frame.
  - Expected: no `chk_done`, `P_DATA` cleared.
  - New frame 0x81 even parity, parity bit 0: `par_err` = 0.
- With `ERR_CNT_WIDTH` = 2, inject 5 parity errors.
  - Expected: `err_count` saturates at 3.
  - Then `err_clr` coinciding with a 6th error: `err_count` = 1, sticky = 1.
  - Build without `UART_PARITY_ERR_CNT_EN`: `err_count` stays 0.
